// File: rtl/led_status_sched.sv
// led_status_sched: prescaled fixed-priority scheduler driving the two board status LEDs
module led_status_sched #(
  parameter int CLK_DIV    = 200,
  parameter int FAST_TICKS = 2,
  parameter int SLOW_TICKS = 8,
  parameter int GAP_TICKS  = 6,
  parameter int HOLD_TICKS = 16
) (
  input  logic       CLK_IN,
  input  logic       rst,
  input  logic       err_req,
  input  logic [3:0] err_code,
  input  logic       busy_req,
  input  logic       hb_en,
  output logic       LED_FPGA0,
  output logic       LED_FPGA1,
  output logic [1:0] active_src,
  output logic       err_ack
);
  localparam int PMAX = FAST_TICKS > SLOW_TICKS ? (FAST_TICKS > GAP_TICKS ? FAST_TICKS : GAP_TICKS)
                                                : (SLOW_TICKS > GAP_TICKS ? SLOW_TICKS : GAP_TICKS);
  localparam int PW = $clog2(PMAX + 1);
  localparam int DW = $clog2(CLK_DIV);
  localparam int HW = $clog2(HOLD_TICKS + 1);
  typedef enum logic [2:0] {IDLE, HB, BUSY, ERR_ON, ERR_OFF, ERR_GAP} state_t;
  state_t state, state_n, arb, tgt;
  logic [DW-1:0] div;
  logic [PW-1:0] phase, phase_n;
  logic [HW-1:0] hold, hold_n;
  logic [4:0] burst, burst_n;
  logic led0_n, led1_n, ack_n, go, tick, hold_done;
  assign tick = div == DW'(CLK_DIV - 1);
  assign hold_done = hold <= HW'(1);
  assign active_src = state == IDLE ? 2'd0 : state == HB ? 2'd1 : state == BUSY ? 2'd2 : 2'd3;
  always_ff @(posedge CLK_IN or negedge rst)
    if (!rst) begin
      div       <= '0;
      state     <= IDLE;
      phase     <= '0;
      hold      <= '0;
      burst     <= '0;
      LED_FPGA0 <= 1'b0;
      LED_FPGA1 <= 1'b0;
      err_ack   <= 1'b0;
    end else begin
      div       <= tick ? '0 : div + 1'b1;
      state     <= state_n;
      phase     <= phase_n;
      hold      <= hold_n;
      burst     <= burst_n;
      LED_FPGA0 <= led0_n;
      LED_FPGA1 <= led1_n;
      err_ack   <= ack_n;
    end
  always_comb begin
    arb     = err_req ? ERR_ON : busy_req ? BUSY : hb_en ? HB : IDLE;
    go      = 1'b0;
    tgt     = arb;
    state_n = state;
    phase_n = phase;
    hold_n  = hold;
    burst_n = burst;
    led0_n  = LED_FPGA0;
    led1_n  = LED_FPGA1;
    ack_n   = 1'b0;
    if (tick) begin
      case (state)
        IDLE: go = 1'b1;
        HB:
          if (arb != HB) go = 1'b1;
          else if (phase == PW'(SLOW_TICKS - 1)) begin
            led0_n  = ~LED_FPGA0;
            phase_n = '0;
          end else phase_n = phase + 1'b1;
        BUSY:
          if (err_req || (hold_done && !busy_req)) go = 1'b1;
          else begin
            hold_n = hold_done ? hold : hold - 1'b1;
            if (phase == PW'(FAST_TICKS - 1)) begin
              led1_n  = ~LED_FPGA1;
              phase_n = '0;
            end else phase_n = phase + 1'b1;
          end
        ERR_ON:
          if (phase == PW'(FAST_TICKS - 1)) begin
            state_n = ERR_OFF;
            phase_n = '0;
            led0_n  = 1'b0;
          end else phase_n = phase + 1'b1;
        ERR_OFF:
          if (phase == PW'(FAST_TICKS - 1)) begin
            burst_n = burst - 1'b1;
            phase_n = '0;
            state_n = burst != 5'd1 ? ERR_ON : ERR_GAP;
            led0_n  = burst != 5'd1;
            led1_n  = burst != 5'd1;
          end else phase_n = phase + 1'b1;
        ERR_GAP:
          if (phase == PW'(GAP_TICKS - 1)) begin
            ack_n = 1'b1;
            go    = 1'b1;
          end else phase_n = phase + 1'b1;
        default: begin
          go  = 1'b1;
          tgt = IDLE;
        end
      endcase
      // entering a new owner restarts its pattern from the first phase
      if (go) begin
        state_n = tgt;
        phase_n = '0;
        hold_n  = HW'(HOLD_TICKS);
        led0_n  = tgt == HB || tgt == ERR_ON;
        led1_n  = tgt == BUSY || tgt == ERR_ON;
        burst_n = tgt == ERR_ON ? {err_code == 4'd0, err_code} : burst;
      end
    end
  end
endmodule

// File: tb/tb_led_status_sched.sv
// tb_led_status_sched: per-cycle scoreboard against a closed-form timeline model of the LED scheduler
module tb_led_status_sched;
  localparam int DIV = 4, F = 2, S = 8, G = 6, H = 16;
  logic CLK_IN = 1'b0, rst = 1'b0, err_req = 1'b0, busy_req = 1'b0, hb_en = 1'b0;
  logic [3:0] err_code = 4'd0;
  logic LED_FPGA0, LED_FPGA1, err_ack;
  logic [1:0] active_src;
  int errors = 0, checks = 0;
  logic [4:0] exp_q[$];
  int e = 0, t = 0, t0 = 0, own = 0, n = 0, k = 0, a = 0;
  logic l0, l1, ack;
  logic [4:0] got, want;

  led_status_sched #(.CLK_DIV(DIV), .FAST_TICKS(F), .SLOW_TICKS(S), .GAP_TICKS(G), .HOLD_TICKS(H)) dut (
    .CLK_IN(CLK_IN), .rst(rst), .err_req(err_req), .err_code(err_code), .busy_req(busy_req),
    .hb_en(hb_en), .LED_FPGA0(LED_FPGA0), .LED_FPGA1(LED_FPGA1), .active_src(active_src), .err_ack(err_ack)
  );

  always #5 CLK_IN = ~CLK_IN;

  // owner plus ticks-since-owner-start fully determines the expected outputs
  initial forever begin
    @(posedge CLK_IN or negedge rst);
    if (!rst) begin
      e = 0; t = 0; t0 = 0; own = 0; n = 0;
      exp_q.delete();
    end else begin
      ack = 1'b0;
      e++;
      if ((e - 1) % DIV == DIV - 1) begin
        t++;
        k = t - t0;
        a = err_req ? 3 : busy_req ? 2 : hb_en ? 1 : 0;
        if (own == 0 || (own == 1 && a != 1) || (own == 2 && (err_req || (k >= H && !busy_req)))
            || (own == 3 && k == 2 * F * n + G)) begin
          ack = (own == 3);
          own = a;
          t0 = t;
          if (a == 3) n = (err_code == 4'd0) ? 16 : int'(err_code);
        end
      end
      k = t - t0;
      l0 = 1'b0;
      l1 = 1'b0;
      if (own == 1) l0 = (k / S) % 2 == 0;
      if (own == 2) l1 = (k / F) % 2 == 0;
      if (own == 3 && k < 2 * F * n) begin
        l0 = (k % (2 * F)) < F;
        l1 = 1'b1;
      end
      exp_q.push_back({l0, l1, 2'(own), ack});
    end
  end

  initial forever begin
    @(negedge CLK_IN);
    if (rst && exp_q.size() > 0) begin
      got = {LED_FPGA0, LED_FPGA1, active_src, err_ack};
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL outputs t=%0t {led0,led1,src,ack} got=%b want=%b", $time, got, want);
      end
    end
  end

  task automatic cyc(input int c);
    repeat (c) @(negedge CLK_IN);
  endtask

  task automatic chk_zero(input string nm);
    #1;
    checks++;
    if ({LED_FPGA0, LED_FPGA1, active_src, err_ack} !== 5'b0) begin
      errors++;
      $display("FAIL %s got=%b want=00000", nm, {LED_FPGA0, LED_FPGA1, active_src, err_ack});
    end
  endtask

  initial begin
    cyc(3);
    chk_zero("reset_state");
    rst = 1'b1;
    hb_en = 1'b1;
    cyc(200);
    hb_en = 1'b0;
    cyc(12);
    err_req = 1'b1; err_code = 4'd3;
    cyc(8);
    err_req = 1'b0;
    cyc(90);
    busy_req = 1'b1;
    cyc(DIV);
    busy_req = 1'b0;
    cyc(90);
    busy_req = 1'b1;
    cyc(24);
    err_req = 1'b1; err_code = 4'd0;
    cyc(10);
    err_req = 1'b0;
    cyc(320);
    busy_req = 1'b0;
    cyc(100);
    err_req = 1'b1; err_code = 4'd5;
    cyc(20);
    err_code = 4'd9; err_req = 1'b0;
    cyc(120);
    err_req = 1'b1; err_code = 4'd2;
    cyc(30);
    err_code = 4'd4;
    cyc(90);
    err_req = 1'b0;
    cyc(120);
    hb_en = 1'b1; err_req = 1'b1; err_code = 4'd7;
    cyc(10);
    err_req = 1'b0;
    cyc(20);
    for (int i = 0; i < 40 && !LED_FPGA0; i++) cyc(1);
    #2 rst = 1'b0;
    chk_zero("async_reset");
    hb_en = 1'b0;
    cyc(3);
    chk_zero("held_reset");
    rst = 1'b1;
    cyc(60);
    repeat (120) begin
      hb_en = $urandom_range(0, 3) != 0;
      busy_req = $urandom_range(0, 2) == 0;
      err_req = $urandom_range(0, 5) == 0;
      err_code = 4'($urandom_range(0, 15));
      cyc($urandom_range(1, 40));
    end
    err_req = 1'b0;
    cyc(10);
    checks++;
    if (checks < 1000) begin
      errors++;
      $display("FAIL check_count got=%0d want>=1000", checks);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/led_status_sched.md
Name: led_status_sched

Overview:
- Schedules the two board status LEDs (LED_FPGA0/LED_FPGA1) among three status requesters: error-code burst, busy indicator, and heartbeat.
- Contains the shared blink-timebase prescaler, a fixed-priority arbiter and a pattern state machine.
- Sits at the top level next to the clock input and drives the LED pins directly. It replaces free-running LED toggle logic.

Parameters:
- CLK_DIV, 200, clocks per timebase tick (>=2).
- FAST_TICKS, 2, half-period in ticks for the busy blink and for each error-burst on/off phase.
- SLOW_TICKS, 8, half-period in ticks for the heartbeat blink.
- GAP_TICKS, 6, dark gap in ticks after an error burst.
- HOLD_TICKS, 16, minimum busy display time in ticks.

Ports:
- CLK_IN  input  1  system clock.
- rst  input  1  asynchronous active-low reset.
- err_req  input  1  level; error display requested.
- err_code  input  4  number of blinks in the burst; 0 means 16.
- busy_req  input  1  level; busy display requested.
- hb_en  input  1  level; heartbeat enabled when no other source is active.
- LED_FPGA0  output  1  LED 0, registered.
- LED_FPGA1  output  1  LED 1, registered.
- active_src  output  2  current owner: 0 idle, 1 heartbeat, 2 busy, 3 error.
- err_ack  output  1  one-cycle pulse when an error burst completes.

Behaviour:
- Reset (rst low, async): prescaler=0, phase counter=0, state=IDLE. LED_FPGA0=0, LED_FPGA1=0, active_src=0, err_ack=0. Releasing reset mid-pattern restarts from IDLE; no partial burst resumes.
- Prescaler:
  - Counts 0..CLK_DIV-1 and wraps.
  - tick=1 for exactly one cycle when count==CLK_DIV-1.
  - Runs continuously, independent of state.
- All state changes, phase-counter updates and LED updates occur only on tick cycles and are registered at that edge. err_ack is the one exception (see ERR_GAP).
- Arbitration (evaluated on tick when the state is IDLE, HB, or BUSY with hold expired):
  - Priority: err_req > busy_req > hb_en > idle.
  - In BUSY with the hold not expired, only err_req is evaluated (preemption). busy_req and hb_en are ignored until the hold expires.
- States:
  - IDLE: both LEDs 0, active_src=0.
  - HB: LED_FPGA1=0; LED_FPGA0 toggles every SLOW_TICKS ticks, first toggle to 1 on entry; active_src=1.
  - BUSY:
    - LED_FPGA0=0; LED_FPGA1 toggles every FAST_TICKS ticks, starting at 1 on entry; active_src=2.
    - Hold counter loads HOLD_TICKS on entry and decrements per tick.
    - Once the hold expires, BUSY is left on a tick when busy_req=0, via arbitration.
    - Preemption: err_req=1 on any tick in BUSY moves to ERR_ON at that edge.
  - ERR_ON:
    - On entry, err_code is latched into the burst counter (0 -> 16).
    - LED_FPGA0=1, LED_FPGA1=1 (solid for the whole error sequence); active_src=3.
    - Lasts FAST_TICKS ticks, then ERR_OFF.
  - ERR_OFF: LED_FPGA0=0 for FAST_TICKS ticks. Burst counter decrements on exit. If nonzero -> ERR_ON, else -> ERR_GAP.
  - ERR_GAP:
    - Both LEDs 0 for GAP_TICKS ticks.
    - On the exit tick, err_ack=1 for that single cycle and the arbitration result is taken.
    - If err_req is still 1, a new burst starts with a freshly latched err_code.
- The error sequence (ERR_ON/ERR_OFF/ERR_GAP) is non-preemptable. err_req and err_code changes during it are ignored.
- active_src changes in the same cycle as the LED outputs.
- Counter widths are sized to hold the largest parameter value. No counter may wrap except the prescaler.

Test Plan:
Bench overrides: CLK_DIV=4, FAST_TICKS=2, SLOW_TICKS=8, GAP_TICKS=6, HOLD_TICKS=16.
- Reset, then hb_en=1 only -> active_src=1 within 4 cycles; LED_FPGA0 period 64 cycles (32 high, 32 low); LED_FPGA1 stays 0.
- err_req=1, err_code=3 from IDLE -> LED_FPGA1=1 for the sequence; three LED_FPGA0 pulses each 8 cycles high / 8 low; 24 dark cycles; err_ack high exactly 1 cycle; 72 cycles from ERR_ON entry to ack.
- busy_req pulsed for 1 cycle -> BUSY for 64 cycles (16 ticks) with LED_FPGA1 toggling every 8 cycles, then return to IDLE or HB.
- BUSY active, err_req=1 at hold tick 5 -> preemption at the next tick; err_code=0 yields 16 pulses; busy resumes only after err_ack.
- err_code changed and err_req dropped mid-burst -> burst count unchanged and burst completes; err_req held high past ack -> second burst begins immediately with the new code.
- rst asserted mid-ERR_ON -> LEDs, active_src and err_ack go 0 asynchronously; after release, state is IDLE and no err_ack is issued.
